// File: rtl/sr_pkg.sv
// Shared types and width helpers for the serial-network shift-register clock blocks.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } srState_e;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int widthOf(input int value);
    if (value <= 1) begin
      return 1;
    end else begin
      return $clog2(value);
    end
  endfunction

endpackage

// File: rtl/sr_half_period_cnt.sv
// DIV-cycle divider: counts 0..DIV-1 while enabled, wrapping to 0; tc flags the last cycle.
module sr_half_period_cnt
  import sr_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      load,
  input  logic [widthOf(DIV)-1:0]   loadVal,
  input  logic                      en,
  output logic                      tc
);

  localparam int CW = widthOf(DIV);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter: clear beats load beats count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= {CW{1'b0}};
    end else if (clr) begin
      cnt <= {CW{1'b0}};
    end else if (load) begin
      cnt <= loadVal;
    end else if (en) begin
      if (cnt == TERM) begin
        cnt <= {CW{1'b0}};
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= cnt;
    end
  end

  assign tc = (cnt == TERM);

endmodule

// File: rtl/sr_clock_gen.sv
// Frame-counted, clock-divided data-clock generator for the shift-register chains.
// Optional clock polarity input enabled by defining SRCLK_CPOL_EN.
module sr_clock_gen
  import sr_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV    = 4,
  parameter int BITS   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_CH-1:0]          ch_mask,
  input  logic                       abort,
`ifdef SRCLK_CPOL_EN
  input  logic                       cpol,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [NUM_CH-1:0]          data_clk,
  output logic                       sample_stb,
  output logic                       shift_stb,
  output logic [widthOf(BITS)-1:0]   bit_idx
);

  localparam int IW = widthOf(BITS);
  localparam logic [IW-1:0] LAST_BIT = IW'(BITS - 1);

  srState_e          state;
  logic [NUM_CH-1:0] maskLat;
  logic              cpolLat;
  logic              cpolIn;
  logic              phaseEnd;
  logic              cntEn;
  logic              cntClr;
  logic [NUM_CH-1:0] idleLvl;
  logic [NUM_CH-1:0] activeLvl;

`ifdef SRCLK_CPOL_EN
  assign cpolIn = cpol;
`else
  assign cpolIn = 1'b0;
`endif

  // Divider control and output levels derived from the latched frame setup.
  always_comb begin
    cntEn     = (state == LOW) || (state == HIGH);
    cntClr    = !cntEn || abort;
    idleLvl   = {NUM_CH{cpolLat}};
    activeLvl = maskLat ^ idleLvl;
  end

  sr_half_period_cnt #(
    .DIV (DIV)
  ) uHalfPeriod (
    .clk     (clk),
    .rst     (rst),
    .clr     (cntClr),
    .load    (1'b0),
    .loadVal ({widthOf(DIV){1'b0}}),
    .en      (cntEn),
    .tc      (phaseEnd)
  );

  // Frame FSM with all handshake, strobe and clock outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_clk   <= {NUM_CH{1'b0}};
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      bit_idx    <= {IW{1'b0}};
      maskLat    <= {NUM_CH{1'b0}};
      cpolLat    <= 1'b0;
    end else begin
      done       <= 1'b0;
      sample_stb <= 1'b0;
      shift_stb  <= 1'b0;
      case (state)
        IDLE: begin
          // abort outranks a start presented in the same cycle
          if (start && !abort && (ch_mask != {NUM_CH{1'b0}})) begin
            maskLat  <= ch_mask;
            cpolLat  <= cpolIn;
            data_clk <= {NUM_CH{cpolIn}};
            bit_idx  <= {IW{1'b0}};
            busy     <= 1'b1;
            state    <= LOW;
          end else begin
            state <= IDLE;
          end
        end
        LOW: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            data_clk <= idleLvl;
            bit_idx  <= {IW{1'b0}};
          end else if (phaseEnd) begin
            state      <= HIGH;
            data_clk   <= activeLvl;
            sample_stb <= 1'b1;
          end else begin
            state <= LOW;
          end
        end
        HIGH: begin
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            data_clk <= idleLvl;
            bit_idx  <= {IW{1'b0}};
          end else if (phaseEnd) begin
            data_clk  <= idleLvl;
            shift_stb <= 1'b1;
            if (bit_idx == LAST_BIT) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= LOW;
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            state <= HIGH;
          end
        end
        DONE: begin
          state   <= IDLE;
          bit_idx <= {IW{1'b0}};
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          data_clk <= idleLvl;
          bit_idx  <= {IW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_clock_gen.sv
// Directed self-checking bench for sr_clock_gen with NUM_CH=4, DIV=2, BITS=3.
module tb_sr_clock_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] ch_mask;
  logic       abort;
`ifdef SRCLK_CPOL_EN
  logic       cpol;
`endif
  logic       busy;
  logic       done;
  logic [3:0] data_clk;
  logic       sample_stb;
  logic       shift_stb;
  logic [1:0] bit_idx;

  int errCnt;
  int chkCnt;

  sr_clock_gen #(
    .NUM_CH (4),
    .DIV    (2),
    .BITS   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ch_mask    (ch_mask),
    .abort      (abort),
`ifdef SRCLK_CPOL_EN
    .cpol       (cpol),
`endif
    .busy       (busy),
    .done       (done),
    .data_clk   (data_clk),
    .sample_stb (sample_stb),
    .shift_stb  (shift_stb),
    .bit_idx    (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chkCnt++; if (busy !== 1'b0) begin errCnt++; $display("FAIL reset_busy got=%b exp=0", busy); end
    chkCnt++; if (done !== 1'b0) begin errCnt++; $display("FAIL reset_done got=%b exp=0", done); end
    chkCnt++; if (data_clk !== 4'b0000) begin errCnt++; $display("FAIL reset_data_clk got=%b exp=0000", data_clk); end
    chkCnt++; if (sample_stb !== 1'b0) begin errCnt++; $display("FAIL reset_sample got=%b exp=0", sample_stb); end
    chkCnt++; if (shift_stb !== 1'b0) begin errCnt++; $display("FAIL reset_shift got=%b exp=0", shift_stb); end
    chkCnt++; if (bit_idx !== 2'd0) begin errCnt++; $display("FAIL reset_bit_idx got=%0d exp=0", bit_idx); end
    rst = 1'b1;
  endtask

  // Start a frame at cycle 0; optionally re-assert start (mask 1111) or abort in given cycles.
  task automatic runFrame(input logic [3:0] mask, input int reStartCyc, input int abortCyc, input string tag);
    int lastCyc;
    logic [3:0] eClk;
    logic eS, eSh, eD, eB;
    logic [1:0] eIdx;
    logic hi;
    @(negedge clk);
    start = 1'b1;
    ch_mask = mask;
    lastCyc = (abortCyc > 0) ? abortCyc + 1 : 13;
    for (int c = 1; c <= lastCyc; c++) begin
      @(negedge clk);
      if (abortCyc > 0 && c > abortCyc) begin
        eClk = 4'b0000; eS = 1'b0; eSh = 1'b0; eD = 1'b0; eB = 1'b0; eIdx = 2'd0;
      end else begin
        hi   = (c == 3) || (c == 4) || (c == 7) || (c == 8) || (c == 11) || (c == 12);
        eClk = hi ? mask : 4'b0000;
        eS   = (c == 3) || (c == 7) || (c == 11);
        eSh  = (c == 5) || (c == 9) || (c == 13);
        eD   = (c == 13);
        eB   = (c <= 12);
        eIdx = (c <= 4) ? 2'd0 : ((c <= 8) ? 2'd1 : 2'd2);
      end
      chkCnt++; if (data_clk !== eClk) begin errCnt++; $display("FAIL %s_data_clk c=%0d got=%b exp=%b", tag, c, data_clk, eClk); end
      chkCnt++; if (sample_stb !== eS) begin errCnt++; $display("FAIL %s_sample c=%0d got=%b exp=%b", tag, c, sample_stb, eS); end
      chkCnt++; if (shift_stb !== eSh) begin errCnt++; $display("FAIL %s_shift c=%0d got=%b exp=%b", tag, c, shift_stb, eSh); end
      chkCnt++; if (done !== eD) begin errCnt++; $display("FAIL %s_done c=%0d got=%b exp=%b", tag, c, done, eD); end
      chkCnt++; if (busy !== eB) begin errCnt++; $display("FAIL %s_busy c=%0d got=%b exp=%b", tag, c, busy, eB); end
      if (c != 13) begin
        chkCnt++; if (bit_idx !== eIdx) begin errCnt++; $display("FAIL %s_bit_idx c=%0d got=%0d exp=%0d", tag, c, bit_idx, eIdx); end
      end
      if (c == reStartCyc) begin
        start = 1'b1;
        ch_mask = 4'b1111;
      end else begin
        start = 1'b0;
      end
      abort = (c == abortCyc);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_frame();
    runFrame(4'b0101, 0, 0, "frame");
  endtask

  task automatic test_zero_mask();
    @(negedge clk);
    start = 1'b1;
    ch_mask = 4'b0000;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      chkCnt++; if (busy !== 1'b0) begin errCnt++; $display("FAIL zero_mask_busy c=%0d got=%b exp=0", c, busy); end
      chkCnt++; if (done !== 1'b0) begin errCnt++; $display("FAIL zero_mask_done c=%0d got=%b exp=0", c, done); end
      chkCnt++; if (data_clk !== 4'b0000) begin errCnt++; $display("FAIL zero_mask_data_clk c=%0d got=%b exp=0000", c, data_clk); end
    end
  endtask

  task automatic test_start_while_busy();
    runFrame(4'b0101, 6, 0, "restart");
  endtask

  task automatic test_abort();
    runFrame(4'b0101, 0, 8, "abort");
    runFrame(4'b0011, 0, 0, "post_abort");
  endtask

  task automatic test_back_to_back();
    runFrame(4'b1010, 0, 0, "b2b_a");
    runFrame(4'b0110, 0, 0, "b2b_b");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    ch_mask = 4'b0101;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chkCnt++; if (data_clk !== 4'b0101) begin errCnt++; $display("FAIL rst_mid_pre got=%b exp=0101", data_clk); end
    #1 rst = 1'b0;
    #1;
    chkCnt++; if (data_clk !== 4'b0000) begin errCnt++; $display("FAIL rst_mid_data_clk got=%b exp=0000", data_clk); end
    chkCnt++; if (busy !== 1'b0) begin errCnt++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chkCnt++; if (done !== 1'b0 || busy !== 1'b0) begin errCnt++; $display("FAIL rst_mid_after c=%0d done=%b busy=%b exp=0/0", c, done, busy); end
    end
  endtask

`ifdef SRCLK_CPOL_EN
  task automatic test_cpol();
    logic [3:0] eClk;
    logic hi;
    @(negedge clk);
    start = 1'b1;
    ch_mask = 4'b0001;
    cpol = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      cpol = 1'b0;
      hi = (c == 3) || (c == 4) || (c == 7) || (c == 8) || (c == 11) || (c == 12);
      eClk = hi ? 4'b1110 : 4'b1111;
      chkCnt++; if (data_clk !== eClk) begin errCnt++; $display("FAIL cpol_data_clk c=%0d got=%b exp=%b", c, data_clk, eClk); end
      if (c == 3) begin
        chkCnt++; if (sample_stb !== 1'b1) begin errCnt++; $display("FAIL cpol_sample got=%b exp=1", sample_stb); end
      end
    end
  endtask
`endif

  initial begin
    errCnt = 0;
    chkCnt = 0;
    rst = 1'b0;
    start = 1'b0;
    ch_mask = 4'b0000;
    abort = 1'b0;
`ifdef SRCLK_CPOL_EN
    cpol = 1'b0;
`endif
    test_reset();
    test_frame();
    test_zero_mask();
    test_start_while_busy();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef SRCLK_CPOL_EN
    test_cpol();
`endif
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule

// File: doc/sr_clock_gen.md
Name: sr_clock_gen

Overview:
Parametrised shift-register clock generator for the serial network. It drives a gated data clock to up to NUM_CH shift-register channels for one frame of BITS bits per start request. It replaces the level-triggered set/reset dataClk control with a fully synchronous, clock-divided, frame-counted generator with a start/busy/done handshake, per-channel enable mask and abort. It sits between the serial-network controller FSM and the shift-register chains.

Parameters:
NUM_CH, 4, number of independent data-clock outputs (>=1)
DIV, 4, clk cycles per data-clock half-period (>=1)
BITS, 8, data-clock pulses per frame (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  frame request; sampled only in IDLE
ch_mask  input  NUM_CH  channels to clock this frame; latched on accepted start
abort  input  1  synchronous frame abort
busy  output  1  frame in progress
done  output  1  one-cycle pulse at normal frame completion
data_clk  output  NUM_CH  gated data clocks, registered
sample_stb  output  1  one-cycle pulse on each data-clock rising edge
shift_stb  output  1  one-cycle pulse on each data-clock falling edge
bit_idx  output  clog2(BITS) (min 1)  index of current bit, 0..BITS-1

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, data_clk=0, sample_stb=0, shift_stb=0, bit_idx=0, latched mask=0, divider counter=0.
- States: IDLE, LOW, HIGH, DONE.
- IDLE: start=1 with ch_mask!=0 -> latch mask, bit_idx=0, go LOW. start with ch_mask==0 is ignored (no busy, no done).
- LOW: lasts exactly DIV cycles; data_clk=0. Exit -> HIGH.
- HIGH: lasts exactly DIV cycles; data_clk = latched mask. sample_stb high in first HIGH cycle. Exit: if bit_idx==BITS-1 -> DONE, else -> LOW with bit_idx+1 and shift_stb high in that first LOW cycle.
- Final falling edge: shift_stb pulses in the DONE cycle.
- DONE: one cycle; done=1, busy=0, data_clk=0. Then IDLE.
- Timing: start accepted at edge k -> first LOW cycle k+1, first rising edge at cycle k+DIV+1, done at cycle k+2*DIV*BITS+1. Back-to-back start in the cycle after DONE is accepted.
- busy=1 in LOW and HIGH only. start while busy is ignored; the mask is not relatched mid-frame.
- Unmasked channels: data_clk bit held 0 for the whole frame.
- abort=1 in LOW/HIGH: next cycle IDLE, data_clk=0, no done, no strobes, bit_idx=0. abort has priority over start in the same cycle. abort in IDLE/DONE: no effect on the done pulse already issued.
- Reset asserted mid-frame: outputs clear immediately (async); no done.
- Divider counter width is clog2(DIV) (min 1). Counter wraps to 0 at each phase change.

Optional Feature:
Macro SRCLK_CPOL_EN.
- With the macro: adds input cpol (1 bit), latched on accepted start. Idle/LOW level of masked channels = cpol, HIGH level = ~cpol. Unmasked channels and IDLE/DONE/reset idle at the latched cpol (reset value 0). sample_stb/shift_stb stay tied to leading/trailing edges.
- Without the macro: no cpol port; polarity fixed at idle-low.

Decomposition:
- Shared package sr_pkg: state enum typedef (IDLE, LOW, HIGH, DONE) and the width helper function for counter and bit_idx widths.
- One natural sub-module: sr_half_period_cnt (DIV-cycle divider, load/clear/terminal-count output), reused by other serial-network blocks.

Test Plan:
Bench config NUM_CH=4, DIV=2, BITS=3.
- Reset release, start at cycle 0 with ch_mask=4'b0101 -> data_clk=0101 in cycles 3-4, 7-8, 11-12; sample_stb at 3,7,11; shift_stb at 5,9,13; done=1 only at cycle 13; bit_idx 0,1,2.
- start with ch_mask=0 -> busy stays 0, no done, data_clk=0 throughout.
- start asserted again at cycle 6 with ch_mask=1111 -> ignored; data_clk pattern stays 0101; done at cycle 13.
- abort at cycle 8 -> IDLE at cycle 9, data_clk=0, no done, bit_idx=0; new start at cycle 10 runs a full frame.
- rst driven low mid-HIGH (cycle 4, between edges) -> data_clk=0 and busy=0 immediately, before the next edge.
- SRCLK_CPOL_EN with cpol=1, mask=0001 -> data_clk[0] idles 1, low in cycles 3-4; other bits stay 1.
